mux_sel_serializer: RTL and testbench

- Upstream stage for the team's 4:1 mux (`mux_4x1`: data input `i`, select `s`, output `y`).
- Accepts one NUM_IN-bit word per valid/ready handshake and registers it onto the mux data input.
- Sweeps the mux select from 0 to NUM_IN-1, holding each select value for HOLD_CYC cycles, so the mux output `y` becomes a serial bitstream, LSB first.
- Supports back-to-back words with no idle bubble between them.

---
 rtl/mux_sel_serializer_pkg.sv | 26 ++
 rtl/mux_sel_serializer_if.sv | 26 ++
 rtl/mux_sel_serializer_beat_counter.sv | 56 +++++
 rtl/mux_sel_serializer.sv | 115 +++++++++++
 tb/tb_mux_sel_serializer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_serializer_pkg.sv
// Shared types and elaboration-time helpers for the mux select serializer.
package mux_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_NUM_IN   = 4;
  localparam int unsigned DEF_HOLD_CYC = 1;

  // Select width for an n-lane mux (never narrower than 1 bit).
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Hold counter width; a single-cycle hold still keeps a 1-bit counter.
  function automatic int unsigned hold_w(input int unsigned h);
    return (h > 2) ? $clog2(h) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned n, input int unsigned h);
    return (n >= 2) && ((n & (n - 1)) == 0) && (h >= 1);
  endfunction

endpackage

// File: rtl/mux_sel_serializer_if.sv
// Upstream handshake plus mux-facing bus of the serializer.
interface mux_sel_serializer_if
  import mux_ser_pkg::*;
#(
  parameter int unsigned NUM_IN = DEF_NUM_IN,
  parameter int unsigned SEL_W  = sel_w(NUM_IN)
);
  logic              in_valid;
  logic              in_ready;
  logic [NUM_IN-1:0] in_data;
  logic [NUM_IN-1:0] mux_i;
  logic [SEL_W-1:0]  mux_s;
  logic              out_valid;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, mux_i, mux_s, out_valid, out_last, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mux_i, mux_s, out_valid, out_last, busy
  );
endinterface

// File: rtl/mux_sel_serializer_beat_counter.sv
// Nested hold/select counter: select advances once every HOLD_CYC enabled cycles.
module beat_counter
  import mux_ser_pkg::*;
#(
  parameter int unsigned NUM_IN   = DEF_NUM_IN,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned SEL_W    = sel_w(NUM_IN),
  parameter int unsigned HOLD_W   = hold_w(HOLD_CYC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [SEL_W-1:0]  cnt_sel,
  output logic [HOLD_W-1:0] cnt_hold,
  output logic              terminal_c,
  output logic              last_sel_nxt_c
);
  localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(NUM_IN - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC - 1);

  logic [SEL_W-1:0]  sel_d;
  logic [HOLD_W-1:0] hold_d;
  logic              hold_end;

  // Next count; select saturates at SEL_MAX so it never wraps inside a word.
  always_comb begin
    sel_d    = cnt_sel;
    hold_d   = cnt_hold;
    hold_end = (cnt_hold == HOLD_MAX);
    if (clr) begin
      sel_d  = '0;
      hold_d = '0;
    end else if (en) begin
      if (!hold_end) begin
        hold_d = cnt_hold + HOLD_W'(1);
      end else begin
        hold_d = '0;
        if (cnt_sel != SEL_MAX) sel_d = cnt_sel + SEL_W'(1);
      end
    end
    terminal_c     = (cnt_sel == SEL_MAX) && hold_end;
    last_sel_nxt_c = (sel_d == SEL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_sel  <= '0;
      cnt_hold <= '0;
    end else begin
      cnt_sel  <= sel_d;
      cnt_hold <= hold_d;
    end
  end

endmodule

// File: rtl/mux_sel_serializer.sv
// Latches one word per handshake onto the mux data input and sweeps the select
// LSB first, so the downstream 4:1 mux emits the word as a serial bitstream.
module mux_sel_serializer
  import mux_ser_pkg::*;
#(
  parameter int unsigned NUM_IN   = DEF_NUM_IN,
  parameter int unsigned SEL_W    = sel_w(NUM_IN),
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_sel_serializer_if.slave   bus
);
  localparam int unsigned HOLD_W = hold_w(HOLD_CYC);

  if (!params_ok(NUM_IN, HOLD_CYC)) begin : g_bad_params
    $error("mux_sel_serializer: NUM_IN must be a power of two >= 2 and HOLD_CYC >= 1");
  end

  state_e            state_q, state_d;
  logic [NUM_IN-1:0] mux_i_q, mux_i_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q;
  logic              busy_q;
  logic              in_ready_c;
  logic              accept_c;
  logic              cnt_clr, cnt_en;
  logic [SEL_W-1:0]  cnt_sel;
  logic [HOLD_W-1:0] hold_cnt;
  logic              terminal_c;
  logic              last_sel_nxt_c;

  beat_counter #(
    .NUM_IN   (NUM_IN),
    .HOLD_CYC (HOLD_CYC),
    .SEL_W    (SEL_W),
    .HOLD_W   (HOLD_W)
  ) u_beat_counter (
    .clk            (clk),
    .rst            (rst),
    .clr            (cnt_clr),
    .en             (cnt_en),
    .cnt_sel        (cnt_sel),
    .cnt_hold       (hold_cnt),
    .terminal_c     (terminal_c),
    .last_sel_nxt_c (last_sel_nxt_c)
  );

  // Ready when idle or on the last cycle of a word, which allows zero-bubble reloads.
  assign in_ready_c = !rst && ((state_q == IDLE) || terminal_c);
  assign accept_c   = bus.in_valid && in_ready_c;

  always_comb begin
    state_d     = state_q;
    mux_i_d     = mux_i_q;
    out_valid_d = out_valid_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr     = 1'b1;
        out_valid_d = 1'b0;
        if (accept_c) begin
          mux_i_d     = bus.in_data;
          out_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (terminal_c) begin
          cnt_clr = 1'b1;
          if (accept_c) begin
            mux_i_d     = bus.in_data;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mux_i_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_i_q     <= mux_i_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_valid_d && last_sel_nxt_c;
      busy_q      <= (state_d == SHIFT);
    end
  end

  // The hold counter is always parked at zero between words.
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE) assert (hold_cnt == '0);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mux_i     = mux_i_q;
  assign bus.mux_s     = cnt_sel;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Drives identical stimulus into a HOLD_CYC=1 and a HOLD_CYC=3 serializer and
// checks both against per-instance expected-beat queues plus a fixed vector table.
module tb_mux_sel_serializer;
  import mux_ser_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned H1 = 1;
  localparam int unsigned H3 = 3;

  typedef struct packed {
    logic [N-1:0] word;
    logic [1:0]   sel;
    logic         last;
  } beat_t;

  typedef struct {
    bit           r;
    bit           v;
    logic [N-1:0] d;
    bit           e_ov;
    logic [1:0]   e_s;
    bit           e_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  mux_sel_serializer_if #(.NUM_IN(N)) if1 ();
  mux_sel_serializer_if #(.NUM_IN(N)) if3 ();

  mux_sel_serializer #(.NUM_IN(N), .HOLD_CYC(H1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  mux_sel_serializer #(.NUM_IN(N), .HOLD_CYC(H3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  always #5 clk = ~clk;

  beat_t        q1[$];
  beat_t        q3[$];
  logic [N-1:0] idle1, idle3;
  int           n_vec = 0;
  int           n_err = 0;
  bit           obs_ov1, obs_ov3, obs_rdy1;
  logic [1:0]   obs_s1;
  vec_t         tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: check current outputs, drive inputs, check in_ready, update models, advance.
  task automatic step(input bit r, input bit v, input logic [N-1:0] d);
    beat_t b;
    bit    e1, e3;
    if (q1.size() > 0) begin
      b = q1.pop_front();
      chk("ov1", 32'(if1.out_valid), 1);
      chk("mux_i1", 32'(if1.mux_i), 32'(b.word));
      chk("mux_s1", 32'(if1.mux_s), 32'(b.sel));
      chk("last1", 32'(if1.out_last), 32'(b.last));
      chk("busy1", 32'(if1.busy), 1);
    end else begin
      chk("ov1_idle", 32'(if1.out_valid), 0);
      chk("mux_s1_idle", 32'(if1.mux_s), 0);
      chk("last1_idle", 32'(if1.out_last), 0);
      chk("busy1_idle", 32'(if1.busy), 0);
      chk("mux_i1_idle", 32'(if1.mux_i), 32'(idle1));
    end
    if (q3.size() > 0) begin
      b = q3.pop_front();
      chk("ov3", 32'(if3.out_valid), 1);
      chk("mux_i3", 32'(if3.mux_i), 32'(b.word));
      chk("mux_s3", 32'(if3.mux_s), 32'(b.sel));
      chk("last3", 32'(if3.out_last), 32'(b.last));
      chk("busy3", 32'(if3.busy), 1);
    end else begin
      chk("ov3_idle", 32'(if3.out_valid), 0);
      chk("mux_s3_idle", 32'(if3.mux_s), 0);
      chk("last3_idle", 32'(if3.out_last), 0);
      chk("busy3_idle", 32'(if3.busy), 0);
      chk("mux_i3_idle", 32'(if3.mux_i), 32'(idle3));
    end
    obs_ov1 = if1.out_valid;
    obs_ov3 = if3.out_valid;
    obs_s1  = if1.mux_s;

    rst = r;
    if1.in_valid = v; if1.in_data = d;
    if3.in_valid = v; if3.in_data = d;
    #1;
    // Ready exactly when no further beat of the current word is pending.
    e1 = !r && (q1.size() == 0);
    e3 = !r && (q3.size() == 0);
    chk("rdy1", 32'(if1.in_ready), 32'(e1));
    chk("rdy3", 32'(if3.in_ready), 32'(e3));
    obs_rdy1 = if1.in_ready;

    if (r) begin
      q1.delete(); idle1 = '0;
      q3.delete(); idle3 = '0;
    end else if (v) begin
      if (e1) begin
        for (int k = 0; k < int'(N * H1); k++)
          q1.push_back('{word: d, sel: 2'(k / int'(H1)), last: ((k / int'(H1)) == int'(N) - 1)});
        idle1 = d;
      end
      if (e3) begin
        for (int k = 0; k < int'(N * H3); k++)
          q3.push_back('{word: d, sel: 2'(k / int'(H3)), last: ((k / int'(H3)) == int'(N) - 1)});
        idle3 = d;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    int cnt1, cnt3;
    idle1 = '0;
    idle3 = '0;
    rst = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0;
    if3.in_valid = 1'b0; if3.in_data = '0;
    @(posedge clk);
    #1;

    // Reset with a pending offer, single word 0101, back-to-back 0110 then 1101 (HOLD_CYC=1 view).
    tbl[0]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'b0110, 1'b1, 2'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'b1101, 1'b1, 2'd3, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_ov", i), 32'(obs_ov1), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_s", i), 32'(obs_s1), 32'(tbl[i].e_s));
      chk($sformatf("tbl%0d_rdy", i), 32'(obs_rdy1), 32'(tbl[i].e_rdy));
    end
    idle(16);

    // Single word 0111: HOLD_CYC=3 must stay valid for 12 cycles, HOLD_CYC=1 for 4.
    step(1'b0, 1'b1, 4'b0111);
    cnt1 = 0;
    cnt3 = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, '0);
      cnt1 += int'(obs_ov1);
      cnt3 += int'(obs_ov3);
    end
    chk("dur_h1", 32'(cnt1), 32'(N * H1));
    chk("dur_h3", 32'(cnt3), 32'(N * H3));

    // Mid-word reset on the mux_s=2 beat (HOLD_CYC=1), then a fresh word 0011.
    step(1'b0, 1'b1, 4'b1010);
    idle(2);
    step(1'b1, 1'b0, '0);
    chk("pre_rst_sel", 32'(obs_s1), 2);
    step(1'b0, 1'b1, 4'b0011);
    idle(14);

    // Upstream stall: in_data flips to 1111 while in_ready is low; reload only on the final beat.
    step(1'b0, 1'b1, 4'b1001);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 4'b1111);
    idle(16);

    // Random traffic with sporadic offers.
    for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
    idle(16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
